pcie_cfg_tx_engine: RTL
=======================

Name:
pcie_cfg_tx_engine

Overview:
- Root-complex transmit engine for Type 0 configuration requests; it answers the controller's `ctr2tx_*` request/done handshake.
- Converts each request into a Configuration Read 0 (CfgRd0) or Configuration Write 0 (CfgWr0) TLP.
- Drives the TLP onto the 64-bit AXI-Stream transmit interface of the PCIe hard core.
- Pulses a one-cycle done when the last beat is accepted.

Parameters:
- REQUESTER_ID, 16'h0000, requester ID placed in header DW1[31:16].
- TARGET_BUS, 8'h01, completer bus number, DW2[31:24].
- TARGET_DEV, 5'h00, completer device number, DW2[23:19].
- TARGET_FUNC, 3'h0, completer function number, DW2[18:16].

Ports:
- user_clk  in  1  sole clock; all logic on its rising edge.
- user_reset  in  1  synchronous, active-high reset.
- user_lnk_up  in  1  link up; new requests are accepted only while high.
- ctr2tx_type0_cfg_read  in  1  CfgRd0 request level; held until done is seen.
- ctr2tx_type0_cfg_read_tag  in  8  read tag.
- ctr2tx_type0_cfg_read_reg_addr  in  12  read byte address.
- ctr2tx_type0_cfg_read_first_dw_be  in  4  read first DW byte enables.
- tx2ctr_type0_cfg_read_done  out  1  one-cycle pulse: CfgRd0 fully sent.
- ctr2tx_type0_cfg_write  in  1  CfgWr0 request level.
- ctr2tx_type0_cfg_write_tag  in  8  write tag.
- ctr2tx_type0_cfg_write_reg_addr  in  12  write byte address.
- ctr2tx_type0_cfg_write_first_dw_be  in  4  write byte enables.
- ctr2tx_type0_cfg_write_data  in  32  write payload DW, sent unswapped.
- tx2ctr_type0_cfg_write_done  out  1  one-cycle pulse: CfgWr0 fully sent.
- s_axis_tx_tdata  out  64  TLP data.
- s_axis_tx_tkeep  out  8  byte valids.
- s_axis_tx_tlast  out  1  last beat.
- s_axis_tx_tvalid  out  1  beat valid.
- s_axis_tx_tuser  out  4  always 4'h0 (no discontinue, no streaming, no error forwarding, no ECRC).
- s_axis_tx_tready  in  1  core accepts beat.

Behaviour:
- Reset: all outputs 0, including tdata, tkeep, tlast, tvalid, tuser and both done outputs. State returns to IDLE. A reset mid-packet drops tvalid on the next cycle and abandons the packet.
- States: IDLE, BEAT0, BEAT1, DONE, RELEASE.
- IDLE:
  - If user_lnk_up=1 and either request is high, latch tag, reg_addr, BE, data and the kind of request; go to BEAT0.
  - Read has priority when both requests are high; the write is served on a later pass.
  - If user_lnk_up=0, requests wait.
- Header fields:
  - DW0: CfgRd0 = 32'h04000001 (Fmt 000, Type 00100, TC/attr 0, Length 1); CfgWr0 = 32'h44000001.
  - DW1: {REQUESTER_ID, tag, 4'h0 last BE, first_dw_be}.
  - DW2: {TARGET_BUS, TARGET_DEV, TARGET_FUNC, 4'h0, reg_addr[11:8], reg_addr[7:2], 2'b00}. reg_addr[1:0] is ignored.
- BEAT0:
  - Drive tvalid=1, tdata={DW1,DW0}, tkeep=8'hFF, tlast=0.
  - Hold all values stable until tready=1, then go to BEAT1.
- BEAT1:
  - Read: tdata={32'h0,DW2}, tkeep=8'h0F.
  - Write: tdata={data,DW2}, tkeep=8'hFF.
  - tlast=1. Hold until tready=1, then go to DONE.
- Beat cadence: tvalid is never deasserted between BEAT0 and BEAT1, and tvalid never drops without a handshake.
- DONE:
  - tvalid=0.
  - Pulse the done output matching the latched kind for exactly one cycle.
  - Go to RELEASE.
- RELEASE:
  - The controller registers done and drops its request one cycle later, so the request is still high on entry and must not retrigger.
  - Stay until the request of the served kind is 0, then go to IDLE.
  - The other kind's request may stay high throughout and is served from IDLE.
- Latency:
  - Request sampled high in IDLE at edge k: tvalid is high after edge k+1.
  - With tready held at 1: BEAT1 after k+2, done high during the cycle after k+3.
- Link down mid-packet: the packet is completed normally; the core discards it.
- Request deasserted mid-packet: ignored, because the fields are latched; done still pulses.
- No outstanding-request or completion tracking; receive-side logic matches completions by tag.

Test Plan:
- Read, tag 8'h00, reg 12'h080, BE 4'hF, tready=1, defaults -> beat0 tdata=64'h0000000F_04000001, tkeep FF, tlast 0; beat1 tdata=64'h00000000_01000080, tkeep 0F, tlast 1; read_done pulses 1 cycle; write_done stays 0.
- Write, tag 8'h05, reg 12'h078, BE 4'h1, data 32'h00000027 -> beat0 64'h00000501_44000001; beat1 64'h00000027_01000078, tkeep FF; write_done pulses once.
- Read with tready low 3 cycles in BEAT0 and 2 cycles in BEAT1 -> tdata, tkeep and tlast stable while stalled; exactly 2 accepted beats; done pulses once.
- Read and write both high with user_lnk_up=1 -> CfgRd0 first, read_done, then CfgWr0 with no further stimulus, write_done. Each request is held one cycle past its done -> exactly one TLP per request.
- user_lnk_up=0 with read high for 10 cycles -> tvalid stays 0. Raise user_lnk_up -> TLP starts 2 edges later.
- user_reset asserted during BEAT1 -> tvalid, tlast and done are 0 the next cycle. After release, a held request produces one fresh complete TLP.

Source files
------------

// File: rtl/pcie_cfg_tx_engine_if.sv
// 64-bit AXI-Stream transmit bundle toward the PCIe hard core.
// The engine drives it through the master modport and the core sinks it through the slave modport.
interface pcie_cfg_tx_engine_if;
   logic [63:0] s_axis_tx_tdata;
   logic [7:0]  s_axis_tx_tkeep;
   logic        s_axis_tx_tlast;
   logic        s_axis_tx_tvalid;
   logic [3:0]  s_axis_tx_tuser;
   logic        s_axis_tx_tready;

   modport master (
      output s_axis_tx_tdata, s_axis_tx_tkeep, s_axis_tx_tlast,
             s_axis_tx_tvalid, s_axis_tx_tuser,
      input  s_axis_tx_tready
   );

   modport slave (
      input  s_axis_tx_tdata, s_axis_tx_tkeep, s_axis_tx_tlast,
             s_axis_tx_tvalid, s_axis_tx_tuser,
      output s_axis_tx_tready
   );
endinterface

// File: rtl/pcie_cfg_tx_engine.sv
// Root-complex Type 0 configuration request transmitter: turns one controller
// request into a two-beat CfgRd0/CfgWr0 TLP and pulses the matching done.
module pcie_cfg_tx_engine #(
   parameter logic [15:0] REQUESTER_ID = 16'h0000,
   parameter logic [7:0]  TARGET_BUS   = 8'h01,
   parameter logic [4:0]  TARGET_DEV   = 5'h00,
   parameter logic [2:0]  TARGET_FUNC  = 3'h0
) (
   input  logic        user_clk,
   input  logic        user_reset,
   input  logic        user_lnk_up,
   input  logic        ctr2tx_type0_cfg_read,
   input  logic [7:0]  ctr2tx_type0_cfg_read_tag,
   input  logic [11:0] ctr2tx_type0_cfg_read_reg_addr,
   input  logic [3:0]  ctr2tx_type0_cfg_read_first_dw_be,
   output logic        tx2ctr_type0_cfg_read_done,
   input  logic        ctr2tx_type0_cfg_write,
   input  logic [7:0]  ctr2tx_type0_cfg_write_tag,
   input  logic [11:0] ctr2tx_type0_cfg_write_reg_addr,
   input  logic [3:0]  ctr2tx_type0_cfg_write_first_dw_be,
   input  logic [31:0] ctr2tx_type0_cfg_write_data,
   output logic        tx2ctr_type0_cfg_write_done,
   pcie_cfg_tx_engine_if.master axis_tx
);

   localparam logic [2:0] ST_IDLE    = 3'd0;
   localparam logic [2:0] ST_BEAT0   = 3'd1;
   localparam logic [2:0] ST_BEAT1   = 3'd2;
   localparam logic [2:0] ST_DONE    = 3'd3;
   localparam logic [2:0] ST_RELEASE = 3'd4;

   logic [2:0]  state_q, state_d;
   logic        is_write_q, is_write_d;
   logic [7:0]  tag_q, tag_d;
   logic [9:0]  dw_addr_q, dw_addr_d;
   logic [3:0]  be_q, be_d;
   logic [31:0] data_q, data_d;
   logic [63:0] tdata_q, tdata_d;
   logic [7:0]  tkeep_q, tkeep_d;
   logic        tlast_q, tlast_d;
   logic        tvalid_q, tvalid_d;
   logic        rd_done_q, rd_done_d;
   logic        wr_done_q, wr_done_d;
   logic [31:0] dw0, dw1, dw2;

   // Byte offset within the DW is not carried in a configuration header.
   logic unused_addr_bits;
   assign unused_addr_bits = ^{ctr2tx_type0_cfg_read_reg_addr[1:0],
                               ctr2tx_type0_cfg_write_reg_addr[1:0]};

   assign dw0 = is_write_q ? 32'h44000001 : 32'h04000001;
   assign dw1 = {REQUESTER_ID, tag_q, 4'h0, be_q};
   assign dw2 = {TARGET_BUS, TARGET_DEV, TARGET_FUNC, 4'h0, dw_addr_q, 2'b00};

   always_comb begin
      state_d    = state_q;
      is_write_d = is_write_q;
      tag_d      = tag_q;
      dw_addr_d  = dw_addr_q;
      be_d       = be_q;
      data_d     = data_q;
      tdata_d    = tdata_q;
      tkeep_d    = tkeep_q;
      tlast_d    = tlast_q;
      tvalid_d   = tvalid_q;
      rd_done_d  = 1'b0;
      wr_done_d  = 1'b0;
      case (state_q)
         ST_IDLE: begin
            if (user_lnk_up && (ctr2tx_type0_cfg_read || ctr2tx_type0_cfg_write)) begin
               // Read wins a tie; the write stays pending and is taken on a later pass.
               if (ctr2tx_type0_cfg_read) begin
                  is_write_d = 1'b0;
                  tag_d      = ctr2tx_type0_cfg_read_tag;
                  dw_addr_d  = ctr2tx_type0_cfg_read_reg_addr[11:2];
                  be_d       = ctr2tx_type0_cfg_read_first_dw_be;
               end else begin
                  is_write_d = 1'b1;
                  tag_d      = ctr2tx_type0_cfg_write_tag;
                  dw_addr_d  = ctr2tx_type0_cfg_write_reg_addr[11:2];
                  be_d       = ctr2tx_type0_cfg_write_first_dw_be;
               end
               data_d  = ctr2tx_type0_cfg_write_data;
               state_d = ST_BEAT0;
            end
         end
         ST_BEAT0: begin
            if (!tvalid_q) begin
               tvalid_d = 1'b1;
               tdata_d  = {dw1, dw0};
               tkeep_d  = 8'hFF;
               tlast_d  = 1'b0;
            end else if (axis_tx.s_axis_tx_tready) begin
               tdata_d = {(is_write_q ? data_q : 32'h0), dw2};
               tkeep_d = is_write_q ? 8'hFF : 8'h0F;
               tlast_d = 1'b1;
               state_d = ST_BEAT1;
            end
         end
         ST_BEAT1: begin
            if (axis_tx.s_axis_tx_tready) begin
               tvalid_d  = 1'b0;
               tlast_d   = 1'b0;
               tdata_d   = 64'h0;
               tkeep_d   = 8'h00;
               rd_done_d = !is_write_q;
               wr_done_d = is_write_q;
               state_d   = ST_DONE;
            end
         end
         ST_DONE: state_d = ST_RELEASE;
         ST_RELEASE: begin
            // The controller drops its request a cycle after seeing done.
            if (is_write_q ? !ctr2tx_type0_cfg_write : !ctr2tx_type0_cfg_read)
               state_d = ST_IDLE;
         end
         default: state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge user_clk) begin
      if (user_reset) begin
         state_q    <= ST_IDLE;
         is_write_q <= 1'b0;
         tag_q      <= 8'h0;
         dw_addr_q  <= 10'h0;
         be_q       <= 4'h0;
         data_q     <= 32'h0;
         tdata_q    <= 64'h0;
         tkeep_q    <= 8'h00;
         tlast_q    <= 1'b0;
         tvalid_q   <= 1'b0;
         rd_done_q  <= 1'b0;
         wr_done_q  <= 1'b0;
      end else begin
         state_q    <= state_d;
         is_write_q <= is_write_d;
         tag_q      <= tag_d;
         dw_addr_q  <= dw_addr_d;
         be_q       <= be_d;
         data_q     <= data_d;
         tdata_q    <= tdata_d;
         tkeep_q    <= tkeep_d;
         tlast_q    <= tlast_d;
         tvalid_q   <= tvalid_d;
         rd_done_q  <= rd_done_d;
         wr_done_q  <= wr_done_d;
      end
   end

   assign axis_tx.s_axis_tx_tdata  = tdata_q;
   assign axis_tx.s_axis_tx_tkeep  = tkeep_q;
   assign axis_tx.s_axis_tx_tlast  = tlast_q;
   assign axis_tx.s_axis_tx_tvalid = tvalid_q;
   assign axis_tx.s_axis_tx_tuser  = 4'h0;
   assign tx2ctr_type0_cfg_read_done  = rd_done_q;
   assign tx2ctr_type0_cfg_write_done = wr_done_q;

endmodule
